// File: rtl/vis_byte_serialiser.sv
// Turns correlator visibility pairs into a framed byte stream for the host link.
// Each frame: SYNC0, SYNC1, frame count (MSB first), then re/im bytes little-endian.
module vis_byte_serialiser #(
    parameter int         ACCUM = 32,
    parameter logic [7:0] SYNC0 = 8'hA5,
    parameter logic [7:0] SYNC1 = 8'h5A
) (
    input  logic             bus_clock,
    input  logic             bus_reset,
    input  logic [ACCUM-1:0] s_revis_i,
    input  logic [ACCUM-1:0] s_imvis_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic             s_last_i,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic [15:0]      frame_o
);

    localparam int BYTES = ACCUM / 8;
    localparam int NB    = 2 * BYTES;
    localparam int IW    = ($clog2(NB) < 2) ? 2 : $clog2(NB);

    localparam logic [IW-1:0] HEAD_LAST = IW'(3);
    localparam logic [IW-1:0] DATA_LAST = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        LOAD,
        DATA
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [2*ACCUM-1:0] sh_q, sh_d;
    logic               last_q, last_d;
    logic [15:0]        frame_q, frame_d;
    logic [7:0]         data_q, data_d;
    logic               mvalid_q, mvalid_d;
    logic               mlast_q, mlast_d;
    logic               sready_q, sready_d;

    logic               m_fire;
    logic               s_fire;
    logic [7:0]         head_next;

    assign m_fire = mvalid_q && m_ready_i;
    assign s_fire = sready_q && s_valid_i;

    // Header byte that follows the one currently on the bus.
    always_comb begin
        head_next = frame_q[7:0];
        unique case (idx_q)
            IW'(0):  head_next = SYNC1;
            IW'(1):  head_next = frame_q[15:8];
            default: head_next = frame_q[7:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        last_d   = last_q;
        frame_d  = frame_q;
        data_d   = data_q;
        mvalid_d = mvalid_q;
        mlast_d  = mlast_q;
        sready_d = sready_q;

        unique case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    state_d  = HEAD;
                    idx_d    = '0;
                    data_d   = SYNC0;
                    mvalid_d = 1'b1;
                    mlast_d  = 1'b0;
                end
            end
            HEAD: begin
                if (m_fire) begin
                    if (idx_q == HEAD_LAST) begin
                        state_d  = LOAD;
                        idx_d    = '0;
                        mvalid_d = 1'b0;
                        sready_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = head_next;
                    end
                end
            end
            LOAD: begin
                if (s_fire) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    sh_d     = {s_imvis_i, s_revis_i};
                    last_d   = s_last_i;
                    data_d   = s_revis_i[7:0];
                    mvalid_d = 1'b1;
                    mlast_d  = 1'b0;
                    sready_d = 1'b0;
                end
            end
            DATA: begin
                if (m_fire) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d    = '0;
                        mvalid_d = 1'b0;
                        mlast_d  = 1'b0;
                        if (last_q) begin
                            state_d = IDLE;
                            frame_d = frame_q + 16'd1;
                        end else begin
                            state_d  = LOAD;
                            sready_d = 1'b1;
                        end
                    end else begin
                        // sh_q[7:0] is on the bus; shift the next byte down.
                        idx_d   = idx_q + 1'b1;
                        sh_d    = sh_q >> 8;
                        data_d  = sh_q[15:8];
                        mlast_d = last_q && ((idx_q + 1'b1) == DATA_LAST);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clock or posedge bus_reset) begin
        if (bus_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sh_q     <= '0;
            last_q   <= 1'b0;
            frame_q  <= '0;
            data_q   <= '0;
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            sready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            last_q   <= last_d;
            frame_q  <= frame_d;
            data_q   <= data_d;
            mvalid_q <= mvalid_d;
            mlast_q  <= mlast_d;
            sready_q <= sready_d;
        end
    end

    assign s_ready_o = sready_q;
    assign m_data_o  = data_q;
    assign m_valid_o = mvalid_q;
    assign m_last_o  = mlast_q;
    assign frame_o   = frame_q;

endmodule

// File: tb/tb_vis_byte_serialiser.sv
// Directed bench for vis_byte_serialiser: table of visibilities with
// hand-written expected bytes, plus corner-case sequences.
module tb_vis_byte_serialiser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_revis_i = '0;
    logic [31:0] s_imvis_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic        s_last_i = 1'b0;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic        m_last_o;
    logic [15:0] frame_o;

    vis_byte_serialiser #(
        .ACCUM(32),
        .SYNC0(8'hA5),
        .SYNC1(8'h5A)
    ) dut (
        .bus_clock(clk),
        .bus_reset(rst),
        .s_revis_i(s_revis_i),
        .s_imvis_i(s_imvis_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .s_last_i (s_last_i),
        .m_data_o (m_data_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_last_o (m_last_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      re;
        logic [31:0]      im;
        logic             last;
        logic [0:7][7:0]  exp;
    } vec_t;

    vec_t        tbl [7];
    logic [8:0]  got [$];
    logic [8:0]  expq [$];
    int          bubq [$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = '0;
    logic        rnd = 1'b0;

    logic        hold = 1'b0;
    logic [7:0]  hold_d = '0;
    logic        hold_l = 1'b0;
    logic        in_frame = 1'b0;
    int          bub = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Byte collector, bubble counter and stall-stability check.
    always @(negedge clk) begin
        if (rst) begin
            hold     = 1'b0;
            in_frame = 1'b0;
            bub      = 0;
        end else begin
            if (hold) begin
                check("stall stable", {22'd0, m_valid_o, m_last_o, m_data_o},
                      {22'd0, 1'b1, hold_l, hold_d});
            end
            hold   = m_valid_o && !m_ready_i;
            hold_d = m_data_o;
            hold_l = m_last_o;
            if (m_valid_o && m_ready_i) begin
                got.push_back({m_last_o, m_data_o});
                in_frame = 1'b1;
                if (m_last_o) begin
                    bubq.push_back(bub);
                    bub      = 0;
                    in_frame = 1'b0;
                end
            end else if (in_frame && !m_valid_o) begin
                bub++;
            end
        end
    end

    task automatic add_frame(int first, int n);
        expq.push_back({1'b0, 8'hA5});
        expq.push_back({1'b0, 8'h5A});
        expq.push_back({1'b0, exp_cnt[15:8]});
        expq.push_back({1'b0, exp_cnt[7:0]});
        for (int i = first; i < first + n; i++) begin
            for (int b = 0; b < 8; b++) begin
                expq.push_back({tbl[i].last && (b == 7), tbl[i].exp[b]});
            end
        end
        exp_cnt++;
    endtask

    task automatic send_vecs(int first, int n);
        int k;
        for (int i = first; i < first + n; i++) begin
            s_revis_i = tbl[i].re;
            s_imvis_i = tbl[i].im;
            s_last_i  = tbl[i].last;
            s_valid_i = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!s_ready_o && k < 500);
            if (!s_ready_o) begin
                check("send timeout s_ready", {31'd0, s_ready_o}, 1);
                s_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (got.size() < expq.size() && k < 3000) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(string name);
        check({name, " len"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            check($sformatf("%s byte%0d", name, i), {23'd0, got[i]}, {23'd0, expq[i]});
        end
        got.delete();
        expq.delete();
    endtask

    task automatic check_bub(string name, int want);
        int b;
        b = (bubq.size() > 0) ? bubq.pop_front() : -1;
        check(name, b, want);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   nl;
        logic ok;

        tbl[0] = '{32'h11223344, 32'hAABBCCDD, 1'b1,
                   {8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA}};
        tbl[1] = '{32'h00000001, 32'h80000000, 1'b0,
                   {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}};
        tbl[2] = '{32'hDEADBEEF, 32'h01234567, 1'b0,
                   {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01}};
        tbl[3] = '{32'hFFFFFFFF, 32'h0F1E2D3C, 1'b1,
                   {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3C, 8'h2D, 8'h1E, 8'h0F}};
        tbl[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b1,
                   {8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A}};
        tbl[5] = '{32'hCAFEBABE, 32'h00FF00FF, 1'b1,
                   {8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'hFF, 8'h00, 8'hFF, 8'h00}};
        tbl[6] = '{32'h5A5AA5A5, 32'h76543210, 1'b1,
                   {8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h10, 8'h32, 8'h54, 8'h76}};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst m_valid", {31'd0, m_valid_o}, 0);
        check("rst m_last", {31'd0, m_last_o}, 0);
        check("rst m_data", {24'd0, m_data_o}, 0);
        check("rst s_ready", {31'd0, s_ready_o}, 0);
        check("rst frame", {16'd0, frame_o}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle s_ready", {31'd0, s_ready_o}, 0);
        check("idle m_valid", {31'd0, m_valid_o}, 0);

        // Single-visibility frame, full throughput
        bubq.delete();
        add_frame(0, 1);
        send_vecs(0, 1);
        wait_drain();
        check_stream("A1");
        check("A1 frame_o", {16'd0, frame_o}, 1);
        check_bub("A1 bubbles", 1);

        // Three-visibility frame, full throughput
        bubq.delete();
        add_frame(1, 3);
        send_vecs(1, 3);
        wait_drain();
        check_stream("A3");
        check("A3 frame_o", {16'd0, frame_o}, 2);
        check_bub("A3 bubbles", 3);

        // Same frame under random back-pressure
        rnd = 1'b1;
        add_frame(1, 3);
        send_vecs(1, 3);
        wait_drain();
        rnd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_stream("B3");
        check("B3 frame_o", {16'd0, frame_o}, 3);

        // Header starts, s_valid drops, block waits in LOAD
        add_frame(0, 1);
        s_revis_i = tbl[0].re;
        s_imvis_i = tbl[0].im;
        s_last_i  = tbl[0].last;
        s_valid_i = 1'b1;
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        k = 0;
        while (!s_ready_o && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("C reach LOAD", {31'd0, s_ready_o}, 1);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            ok = ok && s_ready_o && !m_valid_o;
        end
        check("C wait ready/no valid", {31'd0, ok}, 1);
        @(posedge clk);
        #1;
        s_valid_i = 1'b1;
        @(negedge clk);
        check("C s_ready at word", {31'd0, s_ready_o}, 1);
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        check("C captured", {22'd0, s_ready_o, m_valid_o, m_data_o},
              {22'd0, 1'b0, 1'b1, 8'h44});
        wait_drain();
        check_stream("C");
        check("C frame_o", {16'd0, frame_o}, 4);

        // Reset in the middle of the data bytes
        got.delete();
        expq.delete();
        send_vecs(0, 1);
        k = 0;
        while (got.size() < 8 && k < 500) begin
            @(negedge clk);
            k++;
        end
        #2;
        check("D pre-reset m_valid", {31'd0, m_valid_o}, 1);
        rst = 1'b1;
        #1;
        check("D async m_valid", {31'd0, m_valid_o}, 0);
        check("D async m_last", {31'd0, m_last_o}, 0);
        check("D async m_data", {24'd0, m_data_o}, 0);
        check("D async s_ready", {31'd0, s_ready_o}, 0);
        check("D async frame", {16'd0, frame_o}, 0);
        nl = 0;
        foreach (got[i]) if (got[i][8]) nl++;
        check("D aborted no last", nl, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        bubq.delete();
        exp_cnt = '0;

        // Three back-to-back single-visibility frames after reset
        add_frame(4, 1);
        add_frame(5, 1);
        add_frame(6, 1);
        send_vecs(4, 3);
        wait_drain();
        check_stream("D3");
        check("D3 frame_o", {16'd0, frame_o}, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vis_byte_serialiser.md
Name: vis_byte_serialiser

Overview:
- Downstream consumer of the correlator visibility bus. Accepts (real, imaginary) accumulator pairs on a valid/ready/last stream.
- Re-emits each frame as an 8-bit valid/ready/last byte stream for the host link (USB/UART FIFO), prefixed with a 4-byte sync/frame-count header.
- Sits in the bus clock domain, directly after the correlator's bus-side output.

Parameters:
- ACCUM, 32, width of each visibility component; must be a multiple of 8; BYTES = ACCUM/8.
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.

Ports:
- bus_clock  input  1  sole clock.
- bus_reset  input  1  asynchronous, active-high reset.
- s_revis_i  input  ACCUM  real component of the visibility.
- s_imvis_i  input  ACCUM  imaginary component of the visibility.
- s_valid_i  input  1  input word valid.
- s_ready_o  output  1  input word accepted when s_valid_i && s_ready_o.
- s_last_i  input  1  final visibility of the frame.
- m_data_o  output  8  output byte.
- m_valid_o  output  1  output byte valid.
- m_ready_i  input  1  downstream accepts the byte when m_valid_o && m_ready_i.
- m_last_o  output  1  final byte of the frame.
- frame_o  output  16  count of completed frames.

Behaviour:
- Clock and reset:
  - Single clock.
  - bus_reset asynchronously forces state IDLE; m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=0, frame_o=0, byte index=0, holding registers=0.
- Output rules:
  - All outputs are registered. There is no combinational path from m_ready_i or s_valid_i to any output.
  - Once m_valid_o=1, m_data_o and m_last_o hold stable until the byte is accepted.
- State machine: IDLE, HEAD, LOAD, DATA.
- IDLE:
  - s_ready_o=0.
  - If s_valid_i=1, go to HEAD and present byte 0 (m_valid_o=1) on the next cycle. No input word is consumed.
- HEAD:
  - Emits 4 bytes in order: SYNC0, SYNC1, frame_o[15:8], frame_o[7:0].
  - Advances one byte per accepted transfer.
  - After the 4th accept, go to LOAD with m_valid_o=0.
- LOAD:
  - s_ready_o=1, m_valid_o=0.
  - On s_valid_i=1, capture s_revis_i, s_imvis_i and s_last_i, then go to DATA.
  - The first data byte is valid on the following cycle.
  - Waits indefinitely if s_valid_i=0.
- DATA:
  - s_ready_o=0.
  - Emits 2*BYTES bytes: real component little-endian (bits [7:0] first), then imaginary component little-endian.
  - m_last_o=1 only on the final imaginary byte, and only if the captured last flag=1.
  - After the final byte is accepted:
    - If captured last=1: frame_o increments (16-bit wrap, 0xFFFF->0x0000) on that same edge, then go to IDLE.
    - Otherwise: go to LOAD.
- Byte index:
  - Counter width is clog2(2*BYTES) or at least 2 bits (covers the 4 header bytes).
  - Cleared on every state entry.
- Throughput:
  - Header costs 4 byte-transfers.
  - Each visibility costs one LOAD cycle plus 2*BYTES transfers.
  - One idle bubble between visibilities and after the header is permitted; no other bubbles are allowed when m_ready_i=1.
- Back-pressure:
  - m_ready_i=0 stalls the byte counter and state.
  - s_ready_o stays 0 outside LOAD.
- Frame count in header: reflects frames completed before this one. The first frame after reset carries 0x0000.
- Edge cases:
  - s_last_i on the first word gives a single-visibility frame.
  - s_valid_i dropping in IDLE after HEAD has started has no effect; the header completes and the block waits in LOAD.
- Mid-operation reset: the partial frame is abandoned with no m_last_o. The next frame starts in IDLE with frame_o=0.

Test Plan:
- Single frame, 1 vis, re=0x11223344, im=0xAABBCCDD, m_ready_i=1 -> bytes A5 5A 00 00 44 33 22 11 DD CC BB AA; m_last_o only on AA; frame_o=1 afterwards.
- Frame of 3 vis, s_last_i on 3rd, m_ready_i=1 -> 28 bytes; m_last_o exactly once (byte 28); exactly one bubble cycle before each visibility's first byte.
- Same 3-vis frame with m_ready_i random 50% -> identical byte sequence; m_data_o/m_last_o never change while m_valid_o=1 and m_ready_i=0.
- Three back-to-back 1-vis frames -> header count bytes 00 00, 00 01, 00 02; frame_o ends at 3.
- s_valid_i held 0 for 20 cycles in LOAD, then one word -> s_ready_o high throughout the wait; word captured on the first valid edge; no spurious m_valid_o.
- bus_reset asserted mid-DATA (byte 5 of 8) -> outputs clear immediately (async); next frame header shows 00 00; no m_last_o from the aborted frame.
